// File: rtl/rs_int_scheduler.sv
// ============================================================================
// Module   : rs_int_scheduler
// Purpose  : Allocation, round-robin issue and release control for one bank
//            of integer reservation-station lines.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rs_int_scheduler #(
   parameter int LINE_NUM        = 8,
   parameter int LINE_ADDR_WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       dispatch_req,
   output logic                       dispatch_ack,
   output logic [LINE_NUM-1:0]        write_en_vec,
   input  logic [LINE_NUM-1:0]        line_ready,
   output logic                       issue_valid,
   output logic [LINE_ADDR_WIDTH-1:0] issue_idx,
   input  logic                       fu_ready,
   output logic [LINE_NUM-1:0]        issue_en_vec,
   input  logic                       release_en,
   input  logic [LINE_ADDR_WIDTH-1:0] release_idx,
   output logic [LINE_NUM-1:0]        line_valid,
   output logic [LINE_ADDR_WIDTH:0]   free_count,
   output logic                       full,
   output logic                       empty
);

   localparam logic [LINE_ADDR_WIDTH:0]   c_CNT_ONE  = 1;
   localparam logic [LINE_ADDR_WIDTH:0]   c_CNT_MAX  = (LINE_ADDR_WIDTH+1)'(LINE_NUM);
   localparam logic [LINE_ADDR_WIDTH-1:0] c_PTR_ONE  = 1;
   localparam logic [LINE_NUM-1:0]        c_LINE_ONE = 1;

   logic [LINE_NUM-1:0]        r_valid;
   logic [LINE_NUM-1:0]        r_issued;
   logic [LINE_ADDR_WIDTH-1:0] r_rr_ptr;
   logic                       r_issue_valid;
   logic [LINE_ADDR_WIDTH-1:0] r_issue_idx;

   logic [LINE_ADDR_WIDTH:0]   w_free_count;
   logic                       w_full;
   logic [LINE_NUM-1:0]        w_alloc_onehot;
   logic                       w_dispatch_ack;
   logic                       w_accept;
   logic [LINE_NUM-1:0]        w_issue_onehot;
   logic [LINE_NUM-1:0]        w_release_onehot;
   logic [LINE_NUM-1:0]        w_eligible;
   logic                       w_found;
   logic [LINE_ADDR_WIDTH-1:0] w_pick;
   logic [LINE_ADDR_WIDTH-1:0] w_cand;
   logic                       w_proto_drop;
   logic [LINE_NUM-1:0]        w_valid_nxt;
   logic [LINE_NUM-1:0]        w_issued_nxt;

   always_comb begin
      w_free_count = c_CNT_MAX;
      for (int i = 0; i < LINE_NUM; i++) begin
         if (r_valid[i]) w_free_count = w_free_count - c_CNT_ONE;
      end
   end

   assign w_full = (w_free_count == '0);

   // Scan downward so the last hit is the lowest free index.
   always_comb begin
      w_alloc_onehot = '0;
      for (int i = LINE_NUM - 1; i >= 0; i--) begin
         if (!r_valid[i]) begin
            w_alloc_onehot    = '0;
            w_alloc_onehot[i] = 1'b1;
         end
      end
   end

   assign w_dispatch_ack   = dispatch_req & ~w_full & ~flush;
   assign w_accept         = r_issue_valid & fu_ready & ~flush;
   assign w_issue_onehot   = c_LINE_ONE << r_issue_idx;
   assign w_release_onehot = release_en ? (c_LINE_ONE << release_idx) : '0;

   // A line leaving this cycle (accepted or released) must not become the next offer.
   assign w_eligible = r_valid & ~r_issued & line_ready & ~w_release_onehot
                     & ~(w_accept ? w_issue_onehot : '0);

   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cand  = '0;
      for (int k = 0; k < LINE_NUM; k++) begin
         w_cand = r_rr_ptr + LINE_ADDR_WIDTH'(k);
         if (!w_found && w_eligible[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   assign w_proto_drop = release_en & r_issue_valid & (release_idx == r_issue_idx)
                       & ~r_issued[r_issue_idx];

   // Release is applied before allocation so freeing a not-yet-valid line cannot cancel it.
   always_comb begin
      w_valid_nxt  = r_valid;
      w_issued_nxt = r_issued;
      if (w_accept) w_issued_nxt = w_issued_nxt | w_issue_onehot;
      w_valid_nxt  = w_valid_nxt & ~w_release_onehot;
      w_issued_nxt = w_issued_nxt & ~w_release_onehot;
      if (w_dispatch_ack) begin
         w_valid_nxt  = w_valid_nxt | w_alloc_onehot;
         w_issued_nxt = w_issued_nxt & ~w_alloc_onehot;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid       <= '0;
         r_issued      <= '0;
         r_rr_ptr      <= '0;
         r_issue_valid <= 1'b0;
         r_issue_idx   <= '0;
      end else if (flush) begin
         r_valid       <= '0;
         r_issued      <= '0;
         r_issue_valid <= 1'b0;
      end else begin
         r_valid  <= w_valid_nxt;
         r_issued <= w_issued_nxt;
         if (w_accept) r_rr_ptr <= r_issue_idx + c_PTR_ONE;
         if (w_proto_drop) begin
            r_issue_valid <= 1'b0;
         end else if (!r_issue_valid || w_accept) begin
            r_issue_valid <= w_found;
            if (w_found) r_issue_idx <= w_pick;
         end
      end
   end

   assign dispatch_ack = w_dispatch_ack;
   assign write_en_vec = w_dispatch_ack ? w_alloc_onehot : '0;
   assign issue_valid  = r_issue_valid;
   assign issue_idx    = r_issue_idx;
   assign issue_en_vec = w_accept ? w_issue_onehot : '0;
   assign line_valid   = r_valid;
   assign free_count   = w_free_count;
   assign full         = w_full;
   assign empty        = (w_free_count == c_CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_rs_int_scheduler.sv
// ============================================================================
// Module   : tb_rs_int_scheduler
// Purpose  : Directed vector table plus hand sequences for rs_int_scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rs_int_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic       dispatch_req = 1'b0;
   logic       dispatch_ack;
   logic [7:0] write_en_vec;
   logic [7:0] line_ready = '0;
   logic       issue_valid;
   logic [2:0] issue_idx;
   logic       fu_ready = 1'b0;
   logic [7:0] issue_en_vec;
   logic       release_en = 1'b0;
   logic [2:0] release_idx = '0;
   logic [7:0] line_valid;
   logic [3:0] free_count;
   logic       full;
   logic       empty;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rs_int_scheduler #(.LINE_NUM(8), .LINE_ADDR_WIDTH(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .dispatch_req (dispatch_req),
      .dispatch_ack (dispatch_ack),
      .write_en_vec (write_en_vec),
      .line_ready   (line_ready),
      .issue_valid  (issue_valid),
      .issue_idx    (issue_idx),
      .fu_ready     (fu_ready),
      .issue_en_vec (issue_en_vec),
      .release_en   (release_en),
      .release_idx  (release_idx),
      .line_valid   (line_valid),
      .free_count   (free_count),
      .full         (full),
      .empty        (empty)
   );

   typedef struct {
      logic       flush;
      logic       req;
      logic [7:0] ready;
      logic       fu;
      logic       rel_en;
      logic [2:0] rel_idx;
      logic       ack;
      logic [7:0] we;
      logic       iv;
      logic [2:0] idx;
      logic [7:0] ien;
      logic [7:0] lv;
      logic [3:0] fc;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic fl, input logic rq, input logic [7:0] rdy, input logic fu,
                      input logic re, input logic [2:0] ri, input logic ack, input logic [7:0] we,
                      input logic iv, input logic [2:0] idx, input logic [7:0] ien,
                      input logic [7:0] lv, input logic [3:0] fc);
      vec_t v;
      v.flush = fl; v.req = rq; v.ready = rdy; v.fu = fu; v.rel_en = re; v.rel_idx = ri;
      v.ack = ack; v.we = we; v.iv = iv; v.idx = idx; v.ien = ien; v.lv = lv; v.fc = fc;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int step, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic rq, input logic [7:0] rdy, input logic fu,
                        input logic re, input logic [2:0] ri);
      @(negedge clk);
      flush = fl; dispatch_req = rq; line_ready = rdy; fu_ready = fu;
      release_en = re; release_idx = ri;
      #1;
   endtask

   task automatic check_state(input int step, input logic [7:0] lv, input logic [3:0] fc,
                              input logic iv);
      check("line_valid", step, 32'(line_valid), 32'(lv));
      check("free_count", step, 32'(free_count), 32'(fc));
      check("full", step, 32'(full), 32'(fc == 4'd0));
      check("empty", step, 32'(empty), 32'(fc == 4'd8));
      check("issue_valid", step, 32'(issue_valid), 32'(iv));
   endtask

   initial begin
      // Fill to full, then the 9th request is refused.
      add(0,1'b0,8'h00,0,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'h00,4'd8);
      for (int k = 1; k <= 8; k++)
         add(0,1'b1,8'h00,0,0,3'd0, 1,8'(1 << (k-1)), 0,3'd0,8'h00, 8'((1 << (k-1)) - 1),4'(9-k));
      add(0,1,8'h00,0,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'hFF,4'd0);
      // Release on a full bank: not allocatable until the next cycle.
      add(0,1,8'h00,0,1,3'd5, 0,8'h00, 0,3'd0,8'h00, 8'hFF,4'd0);
      add(0,1,8'h00,0,0,3'd0, 1,8'h20, 0,3'd0,8'h00, 8'hDF,4'd1);
      add(0,0,8'h00,0,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'hFF,4'd0);
      add(1,1,8'h00,0,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'hFF,4'd0);
      add(0,0,8'h00,0,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'h00,4'd8);
      // Lines 0-3 then back-to-back issue 0,1,2,3 and no re-issue.
      add(0,1,8'h00,0,0,3'd0, 1,8'h01, 0,3'd0,8'h00, 8'h00,4'd8);
      add(0,1,8'h00,0,0,3'd0, 1,8'h02, 0,3'd0,8'h00, 8'h01,4'd7);
      add(0,1,8'h00,0,0,3'd0, 1,8'h04, 0,3'd0,8'h00, 8'h03,4'd6);
      add(0,1,8'h00,0,0,3'd0, 1,8'h08, 0,3'd0,8'h00, 8'h07,4'd5);
      add(0,0,8'h0F,1,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'h0F,4'd4);
      add(0,0,8'h0F,1,0,3'd0, 0,8'h00, 1,3'd0,8'h01, 8'h0F,4'd4);
      add(0,0,8'h0F,1,0,3'd0, 0,8'h00, 1,3'd1,8'h02, 8'h0F,4'd4);
      add(0,0,8'h0F,1,0,3'd0, 0,8'h00, 1,3'd2,8'h04, 8'h0F,4'd4);
      add(0,0,8'h0F,1,0,3'd0, 0,8'h00, 1,3'd3,8'h08, 8'h0F,4'd4);
      add(0,0,8'h0F,1,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'h0F,4'd4);
      add(0,0,8'h0F,1,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'h0F,4'd4);
      // Flush keeps rr_ptr=4; hold line 2 while line 0 becomes ready.
      add(1,0,8'h00,0,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'h0F,4'd4);
      add(0,1,8'h00,0,0,3'd0, 1,8'h01, 0,3'd0,8'h00, 8'h00,4'd8);
      add(0,1,8'h00,0,0,3'd0, 1,8'h02, 0,3'd0,8'h00, 8'h01,4'd7);
      add(0,1,8'h00,0,0,3'd0, 1,8'h04, 0,3'd0,8'h00, 8'h03,4'd6);
      add(0,0,8'h04,0,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'h07,4'd5);
      add(0,0,8'h05,0,0,3'd0, 0,8'h00, 1,3'd2,8'h00, 8'h07,4'd5);
      add(0,0,8'h05,0,0,3'd0, 0,8'h00, 1,3'd2,8'h00, 8'h07,4'd5);
      add(0,0,8'h05,0,0,3'd0, 0,8'h00, 1,3'd2,8'h00, 8'h07,4'd5);
      add(0,0,8'h05,1,0,3'd0, 0,8'h00, 1,3'd2,8'h04, 8'h07,4'd5);
      add(0,0,8'h05,1,0,3'd0, 0,8'h00, 1,3'd0,8'h01, 8'h07,4'd5);
      add(0,0,8'h05,1,0,3'd0, 0,8'h00, 0,3'd0,8'h00, 8'h07,4'd5);

      repeat (2) @(negedge clk);
      rst = 1'b1;

      foreach (vecs[s]) begin
         drive(vecs[s].flush, vecs[s].req, vecs[s].ready, vecs[s].fu,
               vecs[s].rel_en, vecs[s].rel_idx);
         check("dispatch_ack", s, 32'(dispatch_ack), 32'(vecs[s].ack));
         check("write_en_vec", s, 32'(write_en_vec), 32'(vecs[s].we));
         check("issue_en_vec", s, 32'(issue_en_vec), 32'(vecs[s].ien));
         check_state(s, vecs[s].lv, vecs[s].fc, vecs[s].iv);
         if (vecs[s].iv) check("issue_idx", s, 32'(issue_idx), 32'(vecs[s].idx));
      end

      // Flush with an offer pending on line 1: no issue pulse, bank empties.
      drive(0,0,8'h00,0,0,3'd0);
      rst = 1'b0;
      #1;
      check_state(100, 8'h00, 4'd8, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (6) drive(0,1,8'h00,0,0,3'd0);
      drive(0,0,8'h02,0,0,3'd0);
      check_state(101, 8'h3F, 4'd2, 1'b0);
      drive(0,0,8'h02,0,0,3'd0);
      check_state(102, 8'h3F, 4'd2, 1'b1);
      check("issue_idx", 102, 32'(issue_idx), 32'd1);
      drive(1,1,8'h02,1,0,3'd0);
      check("issue_en_vec", 103, 32'(issue_en_vec), 32'h00);
      check("dispatch_ack", 103, 32'(dispatch_ack), 32'd0);
      check("write_en_vec", 103, 32'(write_en_vec), 32'h00);
      drive(0,0,8'h00,0,0,3'd0);
      check_state(104, 8'h00, 4'd8, 1'b0);

      // Releasing the offered, unissued line drops the offer.
      repeat (2) drive(0,1,8'h00,0,0,3'd0);
      drive(0,0,8'h02,0,0,3'd0);
      drive(0,0,8'h02,0,1,3'd1);
      check_state(105, 8'h03, 4'd6, 1'b1);
      check("issue_idx", 105, 32'(issue_idx), 32'd1);
      drive(0,0,8'h02,0,0,3'd0);
      check_state(106, 8'h01, 4'd7, 1'b0);

      // Asynchronous reset between edges abandons the offer at once.
      drive(0,0,8'h01,0,0,3'd0);
      drive(0,0,8'h01,0,0,3'd0);
      check_state(107, 8'h01, 4'd7, 1'b1);
      check("issue_idx", 107, 32'(issue_idx), 32'd0);
      #1;
      rst = 1'b0;
      #1;
      check_state(108, 8'h00, 4'd8, 1'b0);
      check("issue_en_vec", 108, 32'(issue_en_vec), 32'h00);
      @(negedge clk);
      rst = 1'b1;
      line_ready = '0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rs_int_scheduler.md
Name: rs_int_scheduler

Overview:
- Controls one bank of integer reservation-station lines.
- Allocates a free line to each dispatched instruction by driving that line's write enable.
- Picks ready lines round-robin and offers one per cycle to the integer functional unit over a valid/ready handshake, pulsing the chosen line's issue enable on acceptance.
- Frees lines once the ROB has consumed their commit data; supports pipeline flush.

Parameters:
- LINE_NUM, 8, number of RS lines managed (power of two, ≥2).
- LINE_ADDR_WIDTH, 3, log2(LINE_NUM).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all lines and any pending offer.
- dispatch_req  in  1  dispatcher has an instruction for this bank.
- dispatch_ack  out  1  allocation accepted this cycle.
- write_en_vec  out  LINE_NUM  one-hot write enable to the allocated line.
- line_ready  in  LINE_NUM  per-line "operands resolved" (line state = ISSUE).
- issue_valid  out  1  offer to the FU is valid.
- issue_idx  out  LINE_ADDR_WIDTH  index of the offered line (muxes its opgen/operands).
- fu_ready  in  1  FU accepts the offer.
- issue_en_vec  out  LINE_NUM  one-hot issue enable to the accepted line.
- release_en  in  1  free a line.
- release_idx  in  LINE_ADDR_WIDTH  line to free.
- line_valid  out  LINE_NUM  occupancy vector.
- free_count  out  LINE_ADDR_WIDTH+1  number of unoccupied lines.
- full  out  1  free_count == 0.
- empty  out  1  free_count == LINE_NUM.

Behaviour:
- State registers: valid[LINE_NUM], issued[LINE_NUM], rr_ptr, issue_valid, issue_idx.
- Reset (async assert): valid=0, issued=0, rr_ptr=0, issue_valid=0, issue_idx=0.
  - Resulting outputs: line_valid=0, free_count=LINE_NUM, empty=1, full=0, write_en_vec=0, issue_en_vec=0.
- Reset mid-operation abandons any offer immediately.
- Allocation (combinational from registered valid):
  - dispatch_ack = dispatch_req & !full & !flush.
  - On ack, write_en_vec is the one-hot of the lowest-index line with valid=0.
  - Next edge: valid[i]<=1, issued[i]<=0.
  - write_en_vec = 0 whenever there is no ack.
- Release: release_en sets valid[release_idx]<=0 and issued[release_idx]<=0 at the next edge.
  - A line released in cycle t becomes allocatable in t+1, not t.
  - Releasing an invalid line has no effect.
- Eligible line: valid & issued=0 & line_ready.
- Issue offer (registered, 1-cycle latency from eligibility):
  - If issue_valid=0, or the offer is accepted this cycle, search for the next offer.
  - Search starts at rr_ptr (wrapping modulo LINE_NUM) for the first eligible line, excluding the line being accepted this cycle.
  - If found: issue_valid<=1 and issue_idx<=that index; otherwise issue_valid<=0.
- Hold rule: while issue_valid=1 and fu_ready=0, issue_idx stays stable. It is not re-arbitrated, even if a higher-priority line becomes ready.
- Acceptance (issue_valid & fu_ready & !flush):
  - issue_en_vec = one-hot(issue_idx), combinational, same cycle.
  - Next edge: issued[issue_idx]<=1 and rr_ptr<=(issue_idx+1) mod LINE_NUM.
  - Back-to-back acceptance gives one issue per cycle.
- Protocol error: release of the currently offered, unissued line. The scheduler frees the line and drops the offer (issue_valid<=0).
- Flush (synchronous, highest priority):
  - Next edge: valid=0, issued=0, issue_valid=0; rr_ptr is kept.
  - In the flush cycle, dispatch_ack=0 and issue_en_vec=0; any release in that cycle is subsumed.
- Simultaneous allocate and release of different lines in the same cycle: both take effect; free_count stays unchanged.
- free_count, full, empty and line_valid are derived from the registered valid vector only.

Test Plan:
- Reset, then 8 consecutive dispatch_req cycles with LINE_NUM=8 -> write_en_vec = 0x01, 0x02, … 0x80 and acks 1..8. After the 8th: full=1, free_count=0; a 9th req gets dispatch_ack=0.
- Fill lines 0–3, raise line_ready=0x0F, fu_ready=1 -> issue_idx sequence 0,1,2,3 on consecutive cycles, issue_en_vec=0x01,0x02,0x04,0x08, then issue_valid=0. Re-asserting line_ready on the same lines produces no re-issue.
- Hold check: line 2 offered with fu_ready=0 for 3 cycles while line 0 becomes ready -> issue_idx stays 2 with issue_valid=1 throughout. When fu_ready=1, line 2 issues, then line 0 (rr_ptr=3 wraps).
- Full bank with release_idx=5 and dispatch_req asserted in the same cycle -> dispatch_ack=0 that cycle. Next cycle: dispatch_ack=1, write_en_vec=0x20.
- Lines 0–5 valid, offer pending on line 1, flush=1 -> no issue_en pulse. Next cycle: line_valid=0, free_count=8, empty=1, issue_valid=0.
- Assert rst low asynchronously mid-offer between clock edges -> issue_valid=0 and line_valid=0 immediately, without waiting for an edge.
